pwm_deadtime_driver: RTL and testbench
======================================

// Module: pwm_deadtime_driver
// PURPOSE
//  Downstream stage of the PWM generator: turns its single pwm output into a complementary
//  high-side/low-side gate-drive pair with programmable dead time and a latched fault shutdown.
//  Guarantees pwm_hi and pwm_lo are never high together; feeds the half-bridge gate drivers.
// PARAMETERS
//  DT_W   4   width of dead_time input, in clock cycles (max dead time 2**DT_W-1)
// PORTS
//  clk            in   1     system clock; all logic on posedge
//  rst_n          in   1     asynchronous, active-low reset
//  en             in   1     drive enable; 0 forces both outputs low
//  pwm_in         in   1     PWM from generator (same clock domain)
//  dead_time      in   DT_W  dead-time cycles N; 0 = no dead time
//  fault_in       in   1     external fault, active high, synchronous level
//  fault_clr      in   1     one-cycle request to leave FAULT
//  pwm_hi         out  1     high-side gate drive
//  pwm_lo         out  1     low-side gate drive
//  dead_active    out  1     1 while in a dead-time state
//  fault_latched  out  1     1 while in FAULT
// BEHAVIOUR
//  Reset: state=OFF, cnt=0, pwm_q=0; all outputs 0.
//  Input stage: pwm_in registered once into pwm_q. The FSM acts on pwm_q only.
//  States (one-hot): OFF, LO, DT_HI, HI, DT_LO, FAULT.
//  Outputs are Moore, taken straight from state flops (glitch-free):
//   pwm_hi = HI; pwm_lo = LO; dead_active = DT_HI|DT_LO; fault_latched = FAULT.
//  Priority each cycle: fault_in > !en > normal transitions.
//   fault_in=1 in any state -> FAULT next edge (both outputs 0 one cycle after fault_in).
//   en=0 in any non-FAULT state -> OFF next edge.
//  Transitions when en=1 and fault_in=0:
//   OFF   -> LO.
//   LO    : pwm_q=1 -> DT_HI, load cnt=N-1 (N=dead_time); if N=0 go directly to HI.
//   DT_HI : pwm_q=0 -> LO (abort, hi never asserted); else cnt=0 -> HI; else cnt--.
//   HI    : pwm_q=0 -> DT_LO, load cnt=N-1; if N=0 go directly to LO.
//   DT_LO : pwm_q=1 -> HI (abort); else cnt=0 -> LO; else cnt--.
//   FAULT : fault_clr=1 & fault_in=0 -> OFF; fault_clr while fault_in=1 is ignored.
//  Latency: pwm_in rising, sampled at edge t -> pwm_lo falls after t+1;
//   both outputs low for exactly N cycles; pwm_hi rises after edge t+N+1. Same for falling.
//  dead_time is sampled only on entry to DT_*; changes mid-dead-time take effect next transition.
//  Pulses shorter than N cycles are swallowed by the abort path; the opposite output never glitches.
//  cnt is DT_W bits, decrement only; no wrap is reachable (load only when N>=1).
//  Invariant: pwm_hi & pwm_lo == 0 in every cycle, including during reset and fault.
//  Reset mid-operation: asynchronous; outputs go to 0 immediately on rst_n fall.
// STRUCTURE
//  Shared package pwm_pkg: state encoding localparams (one-hot indices), DT_W default.
//  Sub-module pwm_dt_counter: load/decrement/zero-flag counter (load, load_val, dec, zero).
//  Top: input register, FSM next-state logic, state flops, output decode.
// TESTING
//  1 rst_n=0 with pwm_in=1, en=1 -> pwm_hi=pwm_lo=dead_active=fault_latched=0; after release, LO by 2nd edge.
//  2 en=1, N=3, pwm_in 0->1 held 10 cycles -> pwm_lo low 1 cycle after pwm_q, 3 cycles both low, pwm_hi high 7 cycles; mirror on fall.
//  3 N=0, pwm_in toggles every 2 cycles -> direct LO<->HI switching, dead_active never 1, outputs never overlap.
//  4 N=5, pwm_in 1-cycle pulse -> DT_HI aborts to LO, pwm_hi never asserts.
//  5 fault_in=1 during HI -> both outputs 0 next cycle, fault_latched=1; fault_clr with fault_in=1 ignored;
//    drop fault_in, pulse fault_clr -> OFF, then LO.
//  6 en=0 during DT_LO -> OFF next edge; dead_time changed 3->7 mid-DT_HI -> current dead time stays 3.
//  All tests: assertion !(pwm_hi & pwm_lo) checked every cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and defaults for the PWM dead-time driver
`timescale 1ns/1ps
package pwm_pkg;

    localparam int DT_W_DEFAULT = 4;

    // One-hot bit positions; outputs decode single state bits directly.
    localparam int ST_OFF   = 0;
    localparam int ST_LO    = 1;
    localparam int ST_DT_HI = 2;
    localparam int ST_HI    = 3;
    localparam int ST_DT_LO = 4;
    localparam int ST_FAULT = 5;
    localparam int NUM_ST   = 6;

    typedef enum logic [NUM_ST-1:0] {
        S_OFF   = 6'(1 << ST_OFF),
        S_LO    = 6'(1 << ST_LO),
        S_DT_HI = 6'(1 << ST_DT_HI),
        S_HI    = 6'(1 << ST_HI),
        S_DT_LO = 6'(1 << ST_DT_LO),
        S_FAULT = 6'(1 << ST_FAULT)
    } state_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// rtl/pwm_dt_counter.sv - dead-time down counter with load and zero flag
`timescale 1ns/1ps
module pwm_dt_counter #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [DT_W-1:0] r_cnt;

    // Decrement saturates at zero so a stray dec can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/pwm_deadtime_driver.sv
// rtl/pwm_deadtime_driver.sv - complementary gate-drive pair with dead time and latched fault
`timescale 1ns/1ps
module pwm_deadtime_driver
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dead_active,
    output logic            fault_latched
);

    logic            r_pwm_q;
    state_t          r_state;
    logic            w_run;
    logic            w_dt_nz;
    logic            w_zero;
    logic            w_load;
    logic            w_dec;
    logic [DT_W-1:0] w_load_val;

    assign w_run      = en && !fault_in;
    assign w_dt_nz    = (dead_time != '0);
    assign w_load_val = dead_time - 1'b1;

    // Counter loads N-1 on entry to a dead-time state so exactly N cycles elapse.
    assign w_load = w_run && w_dt_nz &&
                    (((r_state == S_LO) && r_pwm_q) || ((r_state == S_HI) && !r_pwm_q));
    assign w_dec  = w_run && !w_zero &&
                    (((r_state == S_DT_HI) && r_pwm_q) || ((r_state == S_DT_LO) && !r_pwm_q));

    pwm_dt_counter #(
        .DT_W (DT_W)
    ) u_dt_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_q <= 1'b0;
            r_state <= S_OFF;
        end else begin
            r_pwm_q <= pwm_in;
            if (fault_in) begin
                r_state <= S_FAULT;
            end else if (r_state == S_FAULT) begin
                if (fault_clr) r_state <= S_OFF;
            end else if (!en) begin
                r_state <= S_OFF;
            end else begin
                case (r_state)
                    S_OFF:   r_state <= S_LO;
                    S_LO:    if (r_pwm_q) r_state <= w_dt_nz ? S_DT_HI : S_HI;
                    S_DT_HI: begin
                        if (!r_pwm_q)    r_state <= S_LO;
                        else if (w_zero) r_state <= S_HI;
                    end
                    S_HI:    if (!r_pwm_q) r_state <= w_dt_nz ? S_DT_LO : S_LO;
                    S_DT_LO: begin
                        if (r_pwm_q)     r_state <= S_HI;
                        else if (w_zero) r_state <= S_LO;
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    // Outputs come straight off single one-hot flops, so they cannot glitch or overlap.
    assign pwm_hi        = r_state[ST_HI];
    assign pwm_lo        = r_state[ST_LO];
    assign dead_active   = r_state[ST_DT_HI] | r_state[ST_DT_LO];
    assign fault_latched = r_state[ST_FAULT];

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// tb/tb_pwm_deadtime_driver.sv - scoreboard bench for the PWM dead-time driver
`timescale 1ns/1ps
module tb_pwm_deadtime_driver;

    localparam int DT_W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            pwm_in = 1'b0;
    logic [DT_W-1:0] dead_time = '0;
    logic            fault_in = 1'b0;
    logic            fault_clr = 1'b0;
    logic            pwm_hi;
    logic            pwm_lo;
    logic            dead_active;
    logic            fault_latched;

    int n_checks = 0;
    int n_errors = 0;
    int hi_cnt = 0;
    int dead_cnt = 0;
    int overlap_cnt = 0;

    logic [3:0] exp_q[$];

    typedef enum int {M_OFF, M_LO, M_DTH, M_HI, M_DTL, M_FLT} mstate_t;
    mstate_t m_st = M_OFF;
    logic    m_q = 1'b0;
    int      m_el = 0;
    int      m_n = 0;

    always #5 clk = ~clk;

    pwm_deadtime_driver #(
        .DT_W (DT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .dead_active   (dead_active),
        .fault_latched (fault_latched)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {pwm_hi, pwm_lo, dead_active, fault_latched};
    endfunction

    function automatic logic [3:0] model_outs();
        return {m_st == M_HI, m_st == M_LO, (m_st == M_DTH) || (m_st == M_DTL), m_st == M_FLT};
    endfunction

    task automatic model_reset();
        m_st = M_OFF; m_q = 1'b0; m_el = 0; m_n = 0;
    endtask

    // Dead time modelled as elapsed cycles counting up to the latched N.
    task automatic model_edge();
        mstate_t nx = m_st;
        if (fault_in) nx = M_FLT;
        else if (m_st == M_FLT) begin
            if (fault_clr) nx = M_OFF;
        end else if (!en) nx = M_OFF;
        else begin
            case (m_st)
                M_OFF: nx = M_LO;
                M_LO: if (m_q) begin
                    if (dead_time == 0) nx = M_HI;
                    else begin nx = M_DTH; m_n = int'(dead_time); m_el = 1; end
                end
                M_DTH: if (!m_q) nx = M_LO; else if (m_el >= m_n) nx = M_HI; else m_el++;
                M_HI: if (!m_q) begin
                    if (dead_time == 0) nx = M_LO;
                    else begin nx = M_DTL; m_n = int'(dead_time); m_el = 1; end
                end
                M_DTL: if (m_q) nx = M_HI; else if (m_el >= m_n) nx = M_LO; else m_el++;
                default: nx = M_OFF;
            endcase
        end
        m_st = nx;
        m_q = pwm_in;
    endtask

    task automatic step(input string tag, input logic e, input logic p, input logic f,
                        input logic c, input logic [DT_W-1:0] dt);
        logic [3:0] exp_v;
        en = e; pwm_in = p; fault_in = f; fault_clr = c; dead_time = dt;
        model_edge();
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check_eq(tag, int'(outs()), int'(exp_v));
        if (pwm_hi && pwm_lo) overlap_cnt++;
        hi_cnt += int'(pwm_hi);
        dead_cnt += int'(dead_active);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        hi_cnt = 0; dead_cnt = 0;
    endtask

    initial begin
        // Reset held with pwm_in and en active
        rst_n = 1'b0; en = 1'b1; pwm_in = 1'b1; dead_time = 4'd3;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", int'(outs()), 0);
        rst_n = 1'b1;
        model_reset();
        step("t1_first_edge", 1, 1, 0, 0, 4'd3);
        check_eq("t1_lo_after_release", int'(pwm_lo), 1);
        repeat (8) step("t1_settle", 1, 0, 0, 0, 4'd3);

        // N=3 rising and falling edges
        clear_counts();
        repeat (10) step("t2_high", 1, 1, 0, 0, 4'd3);
        repeat (12) step("t2_low", 1, 0, 0, 0, 4'd3);
        check_eq("t2_hi_cycles", hi_cnt, 7);
        check_eq("t2_dead_cycles", dead_cnt, 6);

        // N=0 direct switching
        clear_counts();
        for (int i = 0; i < 16; i++) step("t3_toggle", 1, logic'((i / 2) % 2), 0, 0, 4'd0);
        repeat (4) step("t3_tail", 1, 0, 0, 0, 4'd0);
        check_eq("t3_dead_never", dead_cnt, 0);
        check_eq("t3_hi_cycles", hi_cnt, 8);

        // N=5 short pulse swallowed
        clear_counts();
        step("t4_pulse", 1, 1, 0, 0, 4'd5);
        repeat (10) step("t4_low", 1, 0, 0, 0, 4'd5);
        check_eq("t4_hi_never", hi_cnt, 0);
        check_eq("t4_dead_cycles", dead_cnt, 1);

        // Fault during HI
        repeat (6) step("t5_to_hi", 1, 1, 0, 0, 4'd2);
        check_eq("t5_in_hi", int'(pwm_hi), 1);
        step("t5_fault", 1, 1, 1, 0, 4'd2);
        check_eq("t5_fault_outs", int'(outs()), 1);
        step("t5_clr_ignored", 1, 1, 1, 1, 4'd2);
        check_eq("t5_still_fault", int'(fault_latched), 1);
        step("t5_fault_drop", 1, 0, 0, 0, 4'd2);
        step("t5_clr", 1, 0, 0, 1, 4'd2);
        check_eq("t5_off", int'(outs()), 0);
        step("t5_relo", 1, 0, 0, 0, 4'd2);
        check_eq("t5_lo", int'(pwm_lo), 1);

        // en=0 in DT_LO, then dead time changed mid DT_HI
        repeat (6) step("t6_to_hi", 1, 1, 0, 0, 4'd3);
        step("t6_fall", 1, 0, 0, 0, 4'd3);
        step("t6_dtlo", 1, 0, 0, 0, 4'd3);
        check_eq("t6_in_dtlo", int'(dead_active), 1);
        step("t6_disable", 0, 0, 0, 0, 4'd3);
        check_eq("t6_off", int'(outs()), 0);
        repeat (3) step("t6_relo", 1, 0, 0, 0, 4'd3);
        clear_counts();
        step("t6_rise", 1, 1, 0, 0, 4'd3);
        step("t6_dthi", 1, 1, 0, 0, 4'd3);
        repeat (6) step("t6_dt7", 1, 1, 0, 0, 4'd7);
        check_eq("t6_dead_kept3", dead_cnt, 3);
        check_eq("t6_hi_cycles", hi_cnt, 4);

        // Asynchronous reset while HI
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_outs", int'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) step("post_reset", 1, 0, 0, 0, 4'd1);

        check_eq("never_overlap", overlap_cnt, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule
